// File: rtl/cache_fill_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_fill_arb_pkg
//  Description : Shared types for the instruction-cache fill arbiter: the
//                arbiter state encoding and the round-robin pointer width.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_fill_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_GRANT   = 3'd3,
    S_DELIVER = 3'd4
  } state_t;

  // Width of a requester index / round-robin pointer. Kept at least one bit
  // so a degenerate single-requester build still elaborates.
  function automatic int rr_ptr_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_fill_arbiter_rr_priority_select.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_select
//  Description : Combinational round-robin picker. Returns the first set bit
//                of req at or after ptr, wrapping past the top index.
//  Ports       : req  - request vector (N_REQ bits)
//                ptr  - round-robin start position
//                any  - at least one request bit set
//                idx  - selected index (valid only when any=1)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_select
  import cache_fill_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = rr_ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             any,
  output logic [PTR_W-1:0] idx
);

  localparam int DBL_W = 2 * N_REQ;
  localparam logic [DBL_W-1:0] ONE = DBL_W'(1);

  logic [DBL_W-1:0] dbl;
  logic [DBL_W-1:0] keep;
  logic [DBL_W-1:0] masked;

  // The request vector is duplicated and everything below ptr is masked off.
  // The lower copy supplies candidates at/after ptr, the upper (unmasked)
  // copy supplies the wrapped candidates, so the lowest surviving bit is
  // the round-robin winner.
  always_comb begin
    dbl    = {req, req};
    keep   = ~((ONE << ptr) - ONE);
    masked = dbl & keep;
    any    = |req;
    idx    = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = DBL_W - 1; i >= 0; i--) begin
      if (masked[i]) begin
        idx = PTR_W'(i % N_REQ);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_fill_arbiter
//  Description : Shares one instruction-memory read port among N_REQ
//                direct-mapped caches. Misses are served round-robin with a
//                single memory transaction in flight; the fill word is held
//                stable for the cycle after the cache's ready pulse.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                req_valid/addr    - per-cache miss requests (addr flattened)
//                req_ready         - one-hot fill-accept pulse
//                req_data          - fill word broadcast to all caches
//                mem_req_*         - memory read request handshake
//                mem_rsp_*         - memory read response
//                busy              - arbiter not idle
//                proto_err         - sticky: response seen outside S_WAIT
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_arbiter
  import cache_fill_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  output logic [N_REQ-1:0]              req_ready,
  output logic [DATA_WIDTH-1:0]         req_data,
  output logic                          mem_req_valid,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  input  logic                          mem_req_ready,
  input  logic                          mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]         mem_rsp_data,
  output logic                          busy,
  output logic                          proto_err
);

  localparam int PTR_W = rr_ptr_width(N_REQ);

  state_t                 state;
  state_t                 state_nxt;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       sel_idx;
  logic [PTR_W-1:0]       sel_idx_inc;
  logic [ADDR_WIDTH-1:0]  addr_saved;
  logic [DATA_WIDTH-1:0]  data_reg;

  logic                   pick_any;
  logic [PTR_W-1:0]       pick_idx;
  logic [ADDR_WIDTH-1:0]  pick_addr;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic                   grant_ok;

  rr_priority_select #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Slot address muxes: the candidate being picked now, and the slot that
  // owns the in-flight transaction (re-checked before granting the fill).
  always_comb begin
    pick_addr = '0;
    sel_addr  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == PTR_W'(i)) pick_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (sel_idx  == PTR_W'(i)) sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // The fill is only handed over if the cache still wants this very block;
  // a withdrawn or retargeted miss simply drops the fetched word.
  assign grant_ok = req_valid[sel_idx] && (sel_addr == addr_saved);

  assign sel_idx_inc = (sel_idx == PTR_W'(N_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      sel_idx    <= '0;
      addr_saved <= '0;
      data_reg   <= '0;
      proto_err  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == S_IDLE && pick_any) begin
        sel_idx    <= pick_idx;
        addr_saved <= pick_addr;
      end

      if (state == S_WAIT && mem_rsp_valid) begin
        data_reg <= mem_rsp_data;
      end

      // Pointer advances past the served slot whether or not the fill was
      // accepted, so a withdrawing cache cannot starve the others.
      if (state == S_GRANT) begin
        rr_ptr <= sel_idx_inc;
      end

      if (mem_rsp_valid && state != S_WAIT) begin
        proto_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (pick_any)      state_nxt = S_ISSUE;
      S_ISSUE:   if (mem_req_ready) state_nxt = S_WAIT;
      S_WAIT:    if (mem_rsp_valid) state_nxt = S_GRANT;
      S_GRANT:   state_nxt = grant_ok ? S_DELIVER : S_IDLE;
      S_DELIVER: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready     = '0;
    mem_req_valid = 1'b0;
    busy          = (state != S_IDLE);
    if (state == S_ISSUE) begin
      mem_req_valid = 1'b1;
    end
    if (state == S_GRANT && grant_ok) begin
      req_ready[sel_idx] = 1'b1;
    end
  end

  assign mem_req_addr = addr_saved;
  assign req_data     = data_reg;

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_fill_arbiter
//  Description : Self-checking bench for cache_fill_arbiter: directed
//                scenarios followed by randomized caches and memory checked
//                against a transaction-level round-robin model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   req_data;
  logic            mem_req_valid;
  logic [AW-1:0]   mem_req_addr;
  logic            mem_req_ready;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rsp_data;
  logic            busy;
  logic            proto_err;

  cache_fill_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .busy          (busy),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Simple immediate-response memory used by the directed scenarios.
  logic          auto_mem = 1'b0;
  logic          acc_flag = 1'b0;
  logic [AW-1:0] acc_addr = '0;
  int            g_idx[$];
  int            g_cyc[$];

  // Randomized-phase model state.
  logic [N-1:0]  pend;
  logic [AW-1:0] paddr [N];
  logic [N-1:0]  snap_prev;
  logic [N-1:0]  exp_ready;
  logic [N-1:0]  got;
  logic          prev_mrv, prev_hold, rsp_pend, rsp_last, grant_exp, dlv_chk;
  logic [AW-1:0] prev_addr, rsp_addr;
  logic [DW-1:0] dlv_data;
  int            rsp_cnt, exp_sel, rr_m, served, base;

  function automatic logic [DW-1:0] hashd(input logic [AW-1:0] a);
    return {20'hABCDE, a, ~a, a ^ 12'h5A5, 8'h3C};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are changed just after the rising edge; outputs are sampled on
  // the falling edge of the same cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mem_rsp_valid = auto_mem && acc_flag;
    mem_rsp_data  = hashd(acc_addr);
  endtask

  task automatic settle();
    @(negedge clk);
    acc_flag = mem_req_valid && mem_req_ready;
    if (acc_flag) acc_addr = mem_req_addr;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        g_idx.push_back(i);
        g_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic cycle();
    tick();
    settle();
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; req_valid = '0; req_addr = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; auto_mem = 1'b0;
    settle();
    tick();
    rst = 1'b0;
    settle();
  endtask

  task automatic wait_ready(input int bound, output logic [N-1:0] r);
    r = '0;
    for (int k = 0; k < bound && r == '0; k++) begin
      cycle();
      r = req_ready;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;

    // ---- reset values ----
    tick(); settle();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_data", req_data, 0);
    chk("rst_proto_err", proto_err, 0);
    tick(); rst = 1'b0; settle();

    // ---- single miss, immediate memory ----
    tick(); req_valid = 4'b0001; req_addr[0 +: AW] = 12'h05A; mem_req_ready = 1'b1; settle();
    chk("s1_c0_busy", busy, 0);
    cycle();
    chk("s1_c1_mem_valid", mem_req_valid, 1);
    chk("s1_c1_mem_addr", mem_req_addr, 12'h05A);
    tick(); mem_rsp_valid = 1'b1; mem_rsp_data = 64'hDEADBEEF_01234567; settle();
    chk("s1_c2_no_ready", req_ready, 0);
    tick(); settle();
    chk("s1_c3_ready", req_ready, 4'b0001);
    tick(); req_valid = '0; settle();
    chk("s1_c4_data", req_data, 64'hDEADBEEF_01234567);
    chk("s1_c4_ready_gone", req_ready, 0);
    cycle();
    chk("s1_c5_idle", busy, 0);

    // ---- round robin, all requesters continuously valid ----
    do_reset();
    g_idx.delete(); g_cyc.delete();
    tick();
    auto_mem = 1'b1; mem_req_ready = 1'b1; req_valid = 4'b1111;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(12'hA00 + i);
    settle();
    base = cyc;
    repeat (25) cycle();
    chk("rr_grant_count", g_idx.size(), 5);
    if (g_idx.size() > 0) chk("rr_first_latency", g_cyc[0] - base, 3);
    for (int k = 0; k < 5 && k < g_idx.size(); k++) begin
      chk("rr_order", g_idx[k], k % N);
      if (k > 0) chk("rr_spacing", g_cyc[k] - g_cyc[k-1], 5);
    end

    // ---- memory backpressure ----
    do_reset();
    tick();
    auto_mem = 1'b1; mem_req_ready = 1'b0; req_valid = 4'b0010; req_addr[1*AW +: AW] = 12'h3C1;
    settle();
    for (int k = 0; k < 7; k++) begin
      cycle();
      chk("bp_hold_valid", mem_req_valid, 1);
      chk("bp_hold_addr", mem_req_addr, 12'h3C1);
    end
    tick(); mem_req_ready = 1'b1; settle();
    chk("bp_accept_valid", mem_req_valid, 1);
    cycle();
    chk("bp_wait_no_ready", req_ready, 0);
    cycle();
    chk("bp_ready", req_ready, 4'b0010);
    tick(); req_valid = '0; settle();
    chk("bp_data", req_data, hashd(12'h3C1));

    // ---- withdrawal during S_WAIT ----
    do_reset();
    tick(); req_valid = 4'b0100; req_addr[2*AW +: AW] = 12'h222; mem_req_ready = 1'b1; settle();
    cycle();
    chk("wd_issue_addr", mem_req_addr, 12'h222);
    tick(); req_valid = 4'b0000; settle();
    chk("wd_wait_busy", busy, 1);
    tick(); mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0BAD_0BAD_0BAD_0BAD; settle();
    chk("wd_wait_no_ready", req_ready, 0);
    cycle();
    chk("wd_grant_no_ready", req_ready, 0);
    tick();
    auto_mem = 1'b1; req_valid = 4'b1001;
    req_addr[0*AW +: AW] = 12'h100; req_addr[3*AW +: AW] = 12'h333;
    settle();
    chk("wd_back_idle", busy, 0);
    cycle();
    chk("wd_next_addr", mem_req_addr, 12'h333);
    cycle();
    cycle();
    chk("wd_next_grant", req_ready, 4'b1000);

    // ---- stray response while idle ----
    tick(); req_valid = '0; auto_mem = 1'b0; settle();
    chk("sr_deliver_data", req_data, hashd(12'h333));
    cycle();
    chk("sr_idle", busy, 0);
    chk("sr_perr_before", proto_err, 0);
    tick(); mem_rsp_valid = 1'b1; mem_rsp_data = 64'hFFFF_0000_FFFF_0000; settle();
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("sr_perr_sticky", proto_err, 1);
      chk("sr_data_kept", req_data, hashd(12'h333));
    end

    // ---- reset in S_WAIT ----
    tick(); auto_mem = 1'b1; req_valid = 4'b0010; req_addr[1*AW +: AW] = 12'h111; settle();
    wait_ready(20, got);
    chk("rs_pre_grant", got, 4'b0010);
    tick(); req_valid = '0; settle();
    cycle();
    tick(); auto_mem = 1'b0; req_valid = 4'b0100; req_addr[2*AW +: AW] = 12'h2A2; settle();
    cycle();
    tick(); rst = 1'b1; settle();
    chk("rs_in_wait", busy, 1);
    tick();
    rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h5555_5555_5555_5555;
    req_valid = 4'b0110; req_addr[1*AW +: AW] = 12'h1B1;
    settle();
    chk("rs_req_ready", req_ready, 0);
    chk("rs_mem_req_valid", mem_req_valid, 0);
    chk("rs_busy", busy, 0);
    chk("rs_req_data", req_data, 0);
    chk("rs_proto_err", proto_err, 0);
    tick(); auto_mem = 1'b1; settle();
    chk("rs_late_rsp_perr", proto_err, 1);
    chk("rs_new_addr", mem_req_addr, 12'h1B1);
    wait_ready(20, got);
    chk("rs_new_grant", got, 4'b0010);

    // ---- randomized caches and memory ----
    do_reset();
    rr_m = 0; pend = '0; rsp_pend = 0; rsp_last = 0; rsp_cnt = 0; rsp_addr = '0;
    prev_mrv = 0; prev_hold = 0; prev_addr = '0; snap_prev = '0;
    dlv_chk = 0; dlv_data = '0; served = -1; exp_sel = -1;
    for (int i = 0; i < N; i++) paddr[i] = '0;
    for (int t = 0; t < 1800; t++) begin
      tick();
      grant_exp = rsp_last;
      rsp_last  = 1'b0;
      if (rsp_pend) begin
        if (rsp_cnt == 0) begin
          mem_rsp_valid = 1'b1; mem_rsp_data = hashd(rsp_addr);
          rsp_pend = 1'b0; rsp_last = 1'b1;
        end else begin
          rsp_cnt--;
        end
      end
      if (served >= 0) begin
        pend[served] = 1'b0; req_valid[served] = 1'b0; served = -1;
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && t < 1500 && $urandom_range(3) == 0) begin
          pend[i] = 1'b1;
          paddr[i] = AW'($urandom);
          req_valid[i] = 1'b1;
          req_addr[i*AW +: AW] = paddr[i];
        end
      end
      mem_req_ready = 1'($urandom_range(1));
      settle();

      if (dlv_chk) begin
        chk("rnd_deliver_data", req_data, dlv_data);
        dlv_chk = 1'b0;
      end
      if (prev_hold) begin
        chk("rnd_hold_valid", mem_req_valid, 1);
        chk("rnd_hold_addr", mem_req_addr, prev_addr);
      end
      if (mem_req_valid && !prev_mrv) begin
        exp_sel = rr_pick(snap_prev, rr_m);
        chk("rnd_pick_found", exp_sel >= 0, 1);
        if (exp_sel >= 0) chk("rnd_issue_addr", mem_req_addr, paddr[exp_sel]);
      end
      exp_ready = '0;
      if (grant_exp && exp_sel >= 0) exp_ready[exp_sel] = 1'b1;
      chk("rnd_req_ready", req_ready, exp_ready);
      if (grant_exp && exp_sel >= 0) begin
        rr_m     = (exp_sel + 1) % N;
        served   = exp_sel;
        dlv_chk  = 1'b1;
        dlv_data = hashd(paddr[exp_sel]);
      end
      if (mem_req_valid && mem_req_ready) begin
        rsp_pend = 1'b1;
        rsp_cnt  = $urandom_range(3);
        rsp_addr = mem_req_addr;
      end
      snap_prev = req_valid;
      prev_mrv  = mem_req_valid;
      prev_hold = mem_req_valid && !mem_req_ready;
      prev_addr = mem_req_addr;
    end
    chk("rnd_all_served", pend, 0);
    chk("rnd_end_idle", busy, 0);
    chk("rnd_no_proto_err", proto_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
